// File: rtl/sdram_burst_xfer.sv
// sdram_burst_xfer: burst engine that turns a (base, length) request into a
// sequence of single-word SDRAM FIFO writes or reads.
//
// Write words are fetched from a source buffer by index (src_idx/src_data).
// Read words are returned to a destination buffer (dst_we/dst_idx/dst_data).
// Each channel has a one-deep pending slot, so a start pulse is never lost
// while another burst is running. Write pending wins over read pending.
//
// Optional build macro: SDRAM_XFER_TIMEOUT_EN adds a 16-bit wait watchdog
// that aborts a stuck burst and raises a sticky err flag.
//
// Handshake: write/read are one-cycle request strobes with their address
// and data held stable afterwards. The FIFO accepts a write once wr_full is
// seen low in the wait state, and a read word is valid while rd_empty is low
// in the wait state. A new request is never issued before that acceptance,
// so write and read are never high together.

module sdram_burst_xfer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 25,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_start,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [LEN_W-1:0]  rd_len,
    output logic [LEN_W-1:0]  src_idx,
    input  logic [DATA_W-1:0] src_data,
    output logic              dst_we,
    output logic [LEN_W-1:0]  dst_idx,
    output logic [DATA_W-1:0] dst_data,
    input  logic              wr_full,
    input  logic              rd_empty,
    input  logic [DATA_W-1:0] readdata,
    output logic              write,
    output logic [ADDR_W-1:0] writeaddr,
    output logic [DATA_W-1:0] writedata,
    output logic              read,
    output logic [ADDR_W-1:0] readaddr,
    output logic              busy,
    output logic              wr_done,
    output logic              rd_done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_REQ  = 3'd1,
        W_WAIT = 3'd2,
        R_REQ  = 3'd3,
        R_WAIT = 3'd4
    } state_t;

    state_t state, state_next;

    logic              wr_pend, rd_pend;
    logic [ADDR_W-1:0] wr_pbase, rd_pbase;
    logic [LEN_W-1:0]  wr_plen, rd_plen;
    logic [ADDR_W-1:0] act_base;
    logic [LEN_W-1:0]  act_len;
    logic [LEN_W-1:0]  k;

    logic              last_k;
    logic              take_wr, take_rd;
    logic [ADDR_W-1:0] req_addr;
    logic              timeout;
    logic              abort_w, abort_r;

    assign last_k    = (k == act_len - LEN_W'(1));
    assign take_wr   = (state == IDLE) && wr_pend;
    assign take_rd   = (state == IDLE) && !wr_pend && rd_pend;
    // Truncating add: the address space wraps at 2^ADDR_W.
    assign req_addr  = act_base + ADDR_W'(k);
    assign abort_w   = (state == W_WAIT) && wr_full && timeout;
    assign abort_r   = (state == R_WAIT) && rd_empty && timeout;
    assign src_idx   = k;
    assign busy      = (state != IDLE) || wr_pend || rd_pend;
    assign state_dbg = state;

`ifdef SDRAM_XFER_TIMEOUT_EN
    logic [15:0] wait_cnt;

    assign timeout = (wait_cnt == 16'hFFFF);

    // Count cycles spent in a wait state; any state change restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state_next != state)
            wait_cnt <= '0;
        else if (state == W_WAIT || state == R_WAIT)
            wait_cnt <= wait_cnt + 16'd1;
    end

    // Sticky error flag, set whenever a burst is abandoned by the watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (abort_w || abort_r)
            err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state selection: arbitrate pending bursts, then step per word.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wr_pend)
                    state_next = (wr_plen == '0) ? IDLE : W_REQ;
                else if (rd_pend)
                    state_next = (rd_plen == '0) ? IDLE : R_REQ;
            end
            W_REQ:  state_next = W_WAIT;
            W_WAIT: begin
                if (!wr_full)
                    state_next = last_k ? IDLE : W_REQ;
                else if (timeout)
                    state_next = IDLE;
            end
            R_REQ:  state_next = R_WAIT;
            R_WAIT: begin
                if (!rd_empty)
                    state_next = last_k ? IDLE : R_REQ;
                else if (timeout)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending slots, active burst parameters, word index and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            wr_pbase  <= '0;
            rd_pbase  <= '0;
            wr_plen   <= '0;
            rd_plen   <= '0;
            act_base  <= '0;
            act_len   <= '0;
            k         <= '0;
            write     <= 1'b0;
            writeaddr <= '0;
            writedata <= '0;
            read      <= 1'b0;
            readaddr  <= '0;
            dst_we    <= 1'b0;
            dst_idx   <= '0;
            dst_data  <= '0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            write   <= 1'b0;
            read    <= 1'b0;
            dst_we  <= 1'b0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;

            // A start pulse always lands in the slot, even over a pending one.
            if (wr_start) begin
                wr_pend  <= 1'b1;
                wr_pbase <= wr_base;
                wr_plen  <= wr_len;
            end else if (take_wr) begin
                wr_pend <= 1'b0;
            end

            if (rd_start) begin
                rd_pend  <= 1'b1;
                rd_pbase <= rd_base;
                rd_plen  <= rd_len;
            end else if (take_rd) begin
                rd_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (take_wr) begin
                        act_base <= wr_pbase;
                        act_len  <= wr_plen;
                        k        <= '0;
                        if (wr_plen == '0)
                            wr_done <= 1'b1;
                    end else if (take_rd) begin
                        act_base <= rd_pbase;
                        act_len  <= rd_plen;
                        k        <= '0;
                        if (rd_plen == '0)
                            rd_done <= 1'b1;
                    end
                end
                W_REQ: begin
                    write     <= 1'b1;
                    writeaddr <= req_addr;
                    writedata <= src_data;
                end
                W_WAIT: begin
                    if (!wr_full) begin
                        if (last_k)
                            wr_done <= 1'b1;
                        else
                            k <= k + LEN_W'(1);
                    end else if (abort_w) begin
                        wr_done <= 1'b1;
                    end
                end
                R_REQ: begin
                    read     <= 1'b1;
                    readaddr <= req_addr;
                end
                R_WAIT: begin
                    if (!rd_empty) begin
                        dst_we   <= 1'b1;
                        dst_idx  <= k;
                        dst_data <= readdata;
                        if (last_k)
                            rd_done <= 1'b1;
                        else
                            k <= k + LEN_W'(1);
                    end else if (abort_r) begin
                        rd_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_xfer.sv
// tb_sdram_burst_xfer: directed bench for sdram_burst_xfer. A table of write
// bursts is replayed in a loop; read, arbitration, reset-abort and (when the
// watchdog macro is defined) timeout behaviour use short hand sequences.

module tb_sdram_burst_xfer;

    localparam int DW = 16;
    localparam int AW = 25;
    localparam int LW = 8;

    logic          clk;
    logic          reset;
    logic          wr_start;
    logic [AW-1:0] wr_base;
    logic [LW-1:0] wr_len;
    logic          rd_start;
    logic [AW-1:0] rd_base;
    logic [LW-1:0] rd_len;
    logic [LW-1:0] src_idx;
    logic [DW-1:0] src_data;
    logic          dst_we;
    logic [LW-1:0] dst_idx;
    logic [DW-1:0] dst_data;
    logic          wr_full;
    logic          rd_empty;
    logic [DW-1:0] readdata;
    logic          write;
    logic [AW-1:0] writeaddr;
    logic [DW-1:0] writedata;
    logic          read;
    logic [AW-1:0] readaddr;
    logic          busy;
    logic          wr_done;
    logic          rd_done;
    logic          err;
    logic [2:0]    state_dbg;

    sdram_burst_xfer #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset),
        .wr_start(wr_start), .wr_base(wr_base), .wr_len(wr_len),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .src_idx(src_idx), .src_data(src_data),
        .dst_we(dst_we), .dst_idx(dst_idx), .dst_data(dst_data),
        .wr_full(wr_full), .rd_empty(rd_empty), .readdata(readdata),
        .write(write), .writeaddr(writeaddr), .writedata(writedata),
        .read(read), .readaddr(readaddr),
        .busy(busy), .wr_done(wr_done), .rd_done(rd_done), .err(err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset block ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Source buffer model: word at index i is i + src_off.
    logic [DW-1:0] src_off = '0;
    assign src_data = {8'h00, src_idx} + src_off;

    // ---------------- monitor / event logs ----------------
    logic [AW-1:0] wa_log[$];
    logic [DW-1:0] wd_log[$];
    int            wt_log[$];
    logic [AW-1:0] ra_log[$];
    int            rt_log[$];
    logic [LW-1:0] di_log[$];
    logic [DW-1:0] dd_log[$];
    int wr_done_cnt = 0, rd_done_cnt = 0;
    int wr_done_cyc = 0, rd_done_cyc = 0;
    int overlap_cnt = 0, dbl_cnt = 0;
    logic write_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (write) begin
                wa_log.push_back(writeaddr);
                wd_log.push_back(writedata);
                wt_log.push_back(cyc);
            end
            if (read) begin
                ra_log.push_back(readaddr);
                rt_log.push_back(cyc);
            end
            if (dst_we) begin
                di_log.push_back(dst_idx);
                dd_log.push_back(dst_data);
            end
            if (wr_done) begin
                wr_done_cnt <= wr_done_cnt + 1;
                wr_done_cyc <= cyc;
            end
            if (rd_done) begin
                rd_done_cnt <= rd_done_cnt + 1;
                rd_done_cyc <= cyc;
            end
            if (write && read) overlap_cnt <= overlap_cnt + 1;
            if (write && write_prev) dbl_cnt <= dbl_cnt + 1;
        end
        write_prev <= write && !reset;
    end

    // ---------------- read FIFO responder ----------------
    logic [DW-1:0] rd_data_q[$];
    int rd_delay = 1;
    bit rd_resp_en = 1'b1;

    initial begin
        rd_empty = 1'b1;
        readdata = '0;
        forever begin
            @(negedge clk);
            if (read && rd_resp_en) begin
                repeat (rd_delay) @(negedge clk);
                readdata = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 16'hDEAD;
                rd_empty = 1'b0;
                @(negedge clk);
                rd_empty = 1'b1;
            end
        end
    end

    // ---------------- scoreboard / checking ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [AW-1:0] exp_q[$];
    logic [DW-1:0] expd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa_log.delete(); wd_log.delete(); wt_log.delete();
        ra_log.delete(); rt_log.delete();
        di_log.delete(); dd_log.delete();
    endtask

    task automatic do_write(input logic [AW-1:0] base, input logic [LW-1:0] len, input int hold,
                            output int start_c, output int hold_writes);
        int d0;
        bit held;
        clear_logs();
        d0 = wr_done_cnt;
        held = 1'b0;
        hold_writes = 0;
        wr_base = base;
        wr_len = len;
        wr_start = 1'b1;
        start_c = cyc;
        step();
        wr_start = 1'b0;
        for (int n = 0; n < 400 && wr_done_cnt == d0; n++) begin
            if (hold > 0 && !held && wa_log.size() == 1) begin
                wr_full = 1'b1;
                repeat (hold) step();
                hold_writes = wa_log.size() - 1;
                wr_full = 1'b0;
                held = 1'b1;
            end else begin
                step();
            end
        end
        check("wr_done_once", wr_done_cnt - d0, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] base, input logic [LW-1:0] len, input int budget);
        int d0;
        clear_logs();
        d0 = rd_done_cnt;
        rd_base = base;
        rd_len = len;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        for (int n = 0; n < budget && rd_done_cnt == d0; n++) step();
        check("rd_done_once", rd_done_cnt - d0, 1);
    endtask

    // ---------------- write burst vector table ----------------
    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            hold;
        logic [DW-1:0] off;
        int            exp_n;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
    } wvec_t;

    wvec_t wv[6];

    initial begin
        int start_c, hold_writes, gap_bad, d0;

        wv[0] = '{25'h0000000, 8'd4, 0,  16'h0000, 4, 25'h0000000, 25'h0000003};
        wv[1] = '{25'h1FFFFFF, 8'd2, 0,  16'h1000, 2, 25'h1FFFFFF, 25'h0000000};
        wv[2] = '{25'h0000100, 8'd3, 10, 16'h2000, 3, 25'h0000100, 25'h0000102};
        wv[3] = '{25'h0000055, 8'd0, 0,  16'h3000, 0, 25'h0000000, 25'h0000000};
        wv[4] = '{25'h1FFFFFE, 8'd5, 0,  16'hFFFE, 5, 25'h1FFFFFE, 25'h0000002};
        wv[5] = '{25'h0ABCDEF, 8'd1, 0,  16'h4321, 1, 25'h0ABCDEF, 25'h0ABCDEF};

        reset = 1'b1;
        wr_start = 1'b0; wr_base = '0; wr_len = '0;
        rd_start = 1'b0; rd_base = '0; rd_len = '0;
        wr_full = 1'b0;

        // Reset state.
        #1;
        check("rst_write", write, 0);
        check("rst_read", read, 0);
        check("rst_dst_we", dst_we, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_writeaddr", writeaddr, 0);
        check("rst_readaddr", readaddr, 0);
        check("rst_src_idx", src_idx, 0);
        check("rst_err", err, 0);
        check("rst_state", state_dbg, 0);
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // Table-driven write bursts.
        for (int i = 0; i < 6; i++) begin
            src_off = wv[i].off;
            do_write(wv[i].base, wv[i].len, wv[i].hold, start_c, hold_writes);
            for (int j = 0; j < int'(wv[i].len); j++) begin
                exp_q.push_back(wv[i].base + AW'(j));
                expd_q.push_back(DW'(j) + wv[i].off);
            end
            check($sformatf("w%0d_count", i), wa_log.size(), wv[i].exp_n);
            for (int j = 0; j < wa_log.size() && exp_q.size() > 0; j++) begin
                check($sformatf("w%0d_addr%0d", i, j), wa_log[j], exp_q.pop_front());
                check($sformatf("w%0d_data%0d", i, j), wd_log[j], expd_q.pop_front());
            end
            exp_q.delete();
            expd_q.delete();
            if (wv[i].exp_n > 0 && wa_log.size() > 0) begin
                check($sformatf("w%0d_first", i), wa_log[0], wv[i].exp_first);
                check($sformatf("w%0d_last", i), wa_log[wa_log.size()-1], wv[i].exp_last);
                check($sformatf("w%0d_done_lat", i), wr_done_cyc - wt_log[wt_log.size()-1],
                      (wv[i].hold > 0 && wv[i].exp_n == 1) ? wv[i].hold + 1 : 1);
            end
            if (wv[i].hold > 0)
                check($sformatf("w%0d_no_write_while_full", i), hold_writes, 0);
            if (wv[i].hold == 0 && wa_log.size() > 0) begin
                check($sformatf("w%0d_first_lat", i), wt_log[0] - start_c, 3);
                gap_bad = 0;
                for (int j = 1; j < wt_log.size(); j++)
                    if (wt_log[j] - wt_log[j-1] != 2) gap_bad++;
                check($sformatf("w%0d_gaps", i), gap_bad, 0);
            end
            if (wv[i].exp_n == 0)
                check($sformatf("w%0d_len0_done_lat", i), wr_done_cyc - start_c, 2);
            check($sformatf("w%0d_no_reads", i), ra_log.size(), 0);
            step();
            check($sformatf("w%0d_busy_after", i), busy, 0);
        end

        // Read burst with a slow FIFO.
        rd_delay = 5;
        rd_data_q.delete();
        rd_data_q.push_back(16'hA5A5);
        rd_data_q.push_back(16'h5A5A);
        do_read(25'd3, 8'd2, 200);
        check("rd_count", ra_log.size(), 2);
        check("rd_dst_count", di_log.size(), 2);
        if (ra_log.size() == 2) begin
            check("rd_addr0", ra_log[0], 3);
            check("rd_addr1", ra_log[1], 4);
            check("rd_gap", rt_log[1] - rt_log[0], 7);
        end
        if (di_log.size() == 2) begin
            check("rd_idx0", di_log[0], 0);
            check("rd_data0", dd_log[0], 16'hA5A5);
            check("rd_idx1", di_log[1], 1);
            check("rd_data1", dd_log[1], 16'h5A5A);
        end
        check("rd_no_writes", wa_log.size(), 0);
        step();
        check("rd_busy_after", busy, 0);

        // Simultaneous starts: write runs first, then read.
        rd_delay = 1;
        rd_data_q.delete();
        rd_data_q.push_back(16'h1111);
        rd_data_q.push_back(16'h2222);
        clear_logs();
        d0 = wr_done_cnt;
        src_off = 16'h0700;
        wr_base = 25'h200; wr_len = 8'd2;
        rd_base = 25'h300; rd_len = 8'd2;
        wr_start = 1'b1; rd_start = 1'b1;
        step();
        wr_start = 1'b0; rd_start = 1'b0;
        for (int n = 0; n < 300 && (rd_done_cnt == 0 || ra_log.size() < 2 || rd_done_cyc < rt_log[rt_log.size()-1]); n++)
            step();
        check("sim_wr_done", wr_done_cnt - d0, 1);
        check("sim_wr_count", wa_log.size(), 2);
        check("sim_rd_count", ra_log.size(), 2);
        if (wa_log.size() == 2 && ra_log.size() == 2) begin
            check("sim_waddr1", wa_log[1], 25'h201);
            check("sim_wdata1", wd_log[1], 16'h0701);
            check("sim_raddr0", ra_log[0], 25'h300);
            check("sim_write_before_read", wt_log[1] < rt_log[0], 1);
        end
        check("sim_done_order", wr_done_cyc < rd_done_cyc, 1);
        if (dd_log.size() == 2) begin
            check("sim_rdata0", dd_log[0], 16'h1111);
            check("sim_rdata1", dd_log[1], 16'h2222);
        end
        step();
        check("sim_busy_after", busy, 0);

        // Reset during W_WAIT of word 1 aborts the burst.
        clear_logs();
        src_off = 16'h0000;
        wr_base = 25'h0; wr_len = 8'd4;
        wr_start = 1'b1;
        step();
        wr_start = 1'b0;
        for (int n = 0; n < 50 && wa_log.size() < 2; n++) step();
        check("rstmid_reached_word1", wa_log.size(), 2);
        d0 = wr_done_cnt;
        reset = 1'b1;
        #1;
        check("rstmid_write", write, 0);
        check("rstmid_writeaddr", writeaddr, 0);
        check("rstmid_writedata", writedata, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_src_idx", src_idx, 0);
        check("rstmid_state", state_dbg, 0);
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();
        check("rstmid_no_done", wr_done_cnt - d0, 0);
        check("rstmid_no_more_writes", wa_log.size(), 2);
        src_off = 16'h0300;
        do_write(25'h40, 8'd2, 0, start_c, hold_writes);
        if (wa_log.size() > 0) begin
            check("rstmid_fresh_addr0", wa_log[0], 25'h40);
            check("rstmid_fresh_data0", wd_log[0], 16'h0300);
        end

`ifdef SDRAM_XFER_TIMEOUT_EN
        // Read FIFO never delivers: watchdog aborts after 65535 wait cycles.
        rd_resp_en = 1'b0;
        do_read(25'h10, 8'd1, 70000);
        check("to_err", err, 1);
        check("to_no_dst", di_log.size(), 0);
        if (rt_log.size() == 1)
            check("to_latency", rd_done_cyc - rt_log[0], 65536);
        step();
        check("to_busy_after", busy, 0);
        rd_resp_en = 1'b1;
`else
        check("err_tied_low", err, 0);
`endif

        check("never_write_and_read", overlap_cnt, 0);
        check("write_single_cycle", dbl_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
